// File: rtl/simd_issue_arbiter_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the SIMD issue arbiter.
package simd_issue_arbiter_pkg;

    localparam int N_SRC_DEF       = 4;
    localparam int N_PENDING_DEF   = 8;
    localparam int MAX_PER_SRC_DEF = 4;
    localparam int RR_MAX          = 32;

    typedef logic [$clog2(N_SRC_DEF)-1:0] srcid_t;

    // Rotate by ptr, take the lowest set bit and map it back to a source index.
    // The three steps are fused into a single scan. Returns -1 when req is empty.
    function automatic int rr_pick(input logic [RR_MAX-1:0] req, input int n, input int ptr);
        int idx;
        int pick;
        pick = -1;
        for (int k = 0; k < RR_MAX; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k < n && pick < 0 && req[idx[4:0]]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/simd_issue_arbiter_tag_fifo.sv
// In-order tag FIFO that records the source id of every issued instruction.
module simd_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/simd_issue_arbiter.sv
// Round-robin arbiter sharing one SIMD ALU pipeline between N_SRC issuing drivers,
// with per-source credit counters and in-order commit routing through a tag FIFO.
module simd_issue_arbiter
    import simd_issue_arbiter_pkg::*;
#(
    parameter int N_SRC       = N_SRC_DEF,
    parameter int INST_BW     = 4,
    parameter int WID_BW      = 3,
    parameter int OFS_BW      = 64,
    parameter int N_PENDING   = N_PENDING_DEF,
    parameter int MAX_PER_SRC = MAX_PER_SRC_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_SRC-1:0]           src_rdy,
    output logic [N_SRC-1:0]           src_ack,
    input  logic [N_SRC*INST_BW-1:0]   i_src_pc,
    input  logic [N_SRC*WID_BW-1:0]    i_src_warpid,
    input  logic [N_SRC*OFS_BW-1:0]    i_src_ofs,
    output logic                       dst_rdy,
    input  logic                       dst_ack,
    output logic [INST_BW-1:0]         o_pc,
    output logic [WID_BW-1:0]          o_warpid,
    output logic [OFS_BW-1:0]          o_ofs,
    output logic [$clog2(N_SRC)-1:0]   o_srcid,
    input  logic                       commit_dval,
    output logic [N_SRC-1:0]           src_commit_dval,
    output logic                       o_idle,
    output logic                       o_err
);
    localparam int SW  = $clog2(N_SRC);
    localparam int CW  = $clog2(MAX_PER_SRC+1);
    localparam int FCW = $clog2(N_PENDING+1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PER_SRC);

    // Handshake: a source transfers when src_rdy and src_ack are both high in a cycle;
    // the slot transfers to the pipeline when dst_rdy and dst_ack are both high.
    logic [CW-1:0]  cnt [N_SRC];
    logic [SW-1:0]  ptr;
    logic [N_SRC-1:0] elig;
    logic           slot_free;
    logic           grant;
    logic           commit_hit;
    int             pick;
    logic [SW-1:0]  win;
    logic [SW-1:0]  head;
    logic           fifo_empty;
    logic           fifo_full;
    logic [FCW-1:0] fifo_count;

    // Eligibility uses registered credits only; a same-cycle commit frees room next cycle.
    always_comb begin
        slot_free = !dst_rdy || dst_ack;
        elig      = '0;
        for (int i = 0; i < N_SRC; i++)
            elig[i] = src_rdy[i] && (cnt[i] < CNT_MAX) && !fifo_full && slot_free && !i_rst;
        pick  = rr_pick(RR_MAX'(elig), N_SRC, int'(ptr));
        grant = (pick >= 0);
        win   = grant ? pick[SW-1:0] : '0;
        src_ack = '0;
        if (grant) src_ack[win] = 1'b1;
        commit_hit      = commit_dval && !fifo_empty && !i_rst;
        src_commit_dval = '0;
        if (commit_hit) src_commit_dval[head] = 1'b1;
    end

    assign o_idle = !dst_rdy && (fifo_count == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dst_rdy  <= 1'b0;
            o_pc     <= '0;
            o_warpid <= '0;
            o_ofs    <= '0;
            o_srcid  <= '0;
            ptr      <= '0;
            o_err    <= 1'b0;
            for (int i = 0; i < N_SRC; i++) cnt[i] <= '0;
        end else begin
            if (grant) begin
                dst_rdy  <= 1'b1;
                o_pc     <= i_src_pc[win*INST_BW +: INST_BW];
                o_warpid <= i_src_warpid[win*WID_BW +: WID_BW];
                o_ofs    <= i_src_ofs[win*OFS_BW +: OFS_BW];
                o_srcid  <= win;
                ptr      <= (win == SW'(N_SRC-1)) ? '0 : win + 1'b1;
            end else if (slot_free) begin
                dst_rdy <= 1'b0;
            end
            if (commit_dval && fifo_empty) o_err <= 1'b1;
            for (int i = 0; i < N_SRC; i++) begin
                case ({grant && (win == SW'(i)), commit_hit && (head == SW'(i))})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    simd_tag_fifo #(
        .DEPTH(N_PENDING),
        .W    (SW)
    ) u_tag_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .push     (grant),
        .push_data(win),
        .pop      (commit_hit),
        .pop_data (head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_simd_issue_arbiter.sv
// Randomized and directed bench for simd_issue_arbiter against a queue-based reference model.
module tb_simd_issue_arbiter;
    import simd_issue_arbiter_pkg::*;

    localparam int N_SRC       = 4;
    localparam int INST_BW     = 4;
    localparam int WID_BW      = 3;
    localparam int OFS_BW      = 64;
    localparam int N_PENDING   = 8;
    localparam int MAX_PER_SRC = 4;

    // clock / reset
    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    logic [N_SRC-1:0]         src_rdy;
    logic [N_SRC-1:0]         src_ack;
    logic [N_SRC*INST_BW-1:0] i_src_pc;
    logic [N_SRC*WID_BW-1:0]  i_src_warpid;
    logic [N_SRC*OFS_BW-1:0]  i_src_ofs;
    logic                     dst_rdy;
    logic                     dst_ack;
    logic [INST_BW-1:0]       o_pc;
    logic [WID_BW-1:0]        o_warpid;
    logic [OFS_BW-1:0]        o_ofs;
    logic [$clog2(N_SRC)-1:0] o_srcid;
    logic                     commit_dval;
    logic [N_SRC-1:0]         src_commit_dval;
    logic                     o_idle;
    logic                     o_err;

    simd_issue_arbiter #(
        .N_SRC(N_SRC), .INST_BW(INST_BW), .WID_BW(WID_BW), .OFS_BW(OFS_BW),
        .N_PENDING(N_PENDING), .MAX_PER_SRC(MAX_PER_SRC)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .src_rdy(src_rdy), .src_ack(src_ack),
        .i_src_pc(i_src_pc), .i_src_warpid(i_src_warpid), .i_src_ofs(i_src_ofs),
        .dst_rdy(dst_rdy), .dst_ack(dst_ack),
        .o_pc(o_pc), .o_warpid(o_warpid), .o_ofs(o_ofs), .o_srcid(o_srcid),
        .commit_dval(commit_dval), .src_commit_dval(src_commit_dval),
        .o_idle(o_idle), .o_err(o_err)
    );

    // scoreboard: issued-but-uncommitted source ids in issue order
    int n_tests = 0;
    int n_fail  = 0;
    int obs_grants = 0;
    srcid_t exp_q[$];
    int                 m_ptr;
    logic               m_slot_v;
    logic [INST_BW-1:0] m_pc;
    logic [WID_BW-1:0]  m_wid;
    logic [OFS_BW-1:0]  m_ofs;
    int                 m_sid;
    logic               m_err;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int pending_of(input int s);
        int n = 0;
        foreach (exp_q[k]) if (int'(exp_q[k]) == s) n++;
        return n;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ptr = 0; m_slot_v = 1'b0; m_pc = '0; m_wid = '0; m_ofs = '0; m_sid = 0; m_err = 1'b0;
    endtask

    // driver: one clock cycle of stimulus, check, then advance the model
    task automatic run_cycle(input logic [N_SRC-1:0] rdy, input logic ack, input logic cmt, input logic rst);
        logic [N_SRC-1:0] exp_ack;
        logic [N_SRC-1:0] exp_cmt;
        logic free;
        int win;
        @(negedge i_clk);
        src_rdy = rdy; dst_ack = ack; commit_dval = cmt; i_rst = rst;
        i_src_pc     = (N_SRC*INST_BW)'($urandom());
        i_src_warpid = (N_SRC*WID_BW)'($urandom());
        for (int j = 0; j < N_SRC*OFS_BW/32; j++) i_src_ofs[j*32 +: 32] = $urandom();
        #1;
        check_eq("dst_rdy",  64'(dst_rdy),  64'(m_slot_v));
        check_eq("o_pc",     64'(o_pc),     64'(m_pc));
        check_eq("o_warpid", 64'(o_warpid), 64'(m_wid));
        check_eq("o_ofs",    o_ofs,         m_ofs);
        check_eq("o_srcid",  64'(o_srcid),  64'(m_sid));
        check_eq("o_err",    64'(o_err),    64'(m_err));
        check_eq("o_idle",   64'(o_idle),   64'(!m_slot_v && exp_q.size() == 0));
        free = !m_slot_v || ack;
        win  = -1;
        if (!rst && free && exp_q.size() < N_PENDING) begin
            for (int k = 0; k < N_SRC; k++) begin
                int s;
                s = (m_ptr + k) % N_SRC;
                if (win < 0 && rdy[s] && pending_of(s) < MAX_PER_SRC) win = s;
            end
        end
        exp_ack = (win >= 0) ? (N_SRC'(1) << win) : '0;
        exp_cmt = (!rst && cmt && exp_q.size() > 0) ? (N_SRC'(1) << exp_q[0]) : '0;
        check_eq("src_ack",         64'(src_ack),         64'(exp_ack));
        check_eq("src_commit_dval", 64'(src_commit_dval), 64'(exp_cmt));
        if (src_ack != '0) obs_grants++;
        if (rst) begin
            model_reset();
        end else begin
            if (cmt) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                else m_err = 1'b1;
            end
            if (win >= 0) begin
                exp_q.push_back(srcid_t'(win));
                m_slot_v = 1'b1;
                m_pc  = i_src_pc[win*INST_BW +: INST_BW];
                m_wid = i_src_warpid[win*WID_BW +: WID_BW];
                m_ofs = i_src_ofs[win*OFS_BW +: OFS_BW];
                m_sid = win;
                m_ptr = (win + 1) % N_SRC;
            end else if (free) begin
                m_slot_v = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            run_cycle('0, 1'b1, 1'b1, 1'b0);
            budget--;
        end
        check_eq("drain_budget", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic [N_SRC-1:0] r_rdy;
        logic r_ack, r_cmt, r_rst;
        i_rst = 1'b1; src_rdy = '0; dst_ack = 1'b0; commit_dval = 1'b0;
        i_src_pc = '0; i_src_warpid = '0; i_src_ofs = '0;
        repeat (2) @(posedge i_clk);
        model_reset();
        run_cycle('0, 1'b0, 1'b0, 1'b1);

        // single source: four grants then a credit stall, one commit releases it
        obs_grants = 0;
        repeat (6) run_cycle(4'b0001, 1'b1, 1'b0, 1'b0);
        check_eq("single_grants", 64'(obs_grants), 64'(4));
        run_cycle(4'b0001, 1'b1, 1'b1, 1'b0);
        run_cycle(4'b0001, 1'b1, 1'b0, 1'b0);
        check_eq("single_resume", 64'(obs_grants), 64'(5));
        run_cycle('0, 1'b1, 1'b0, 1'b0);
        drain();
        run_cycle('0, 1'b0, 1'b0, 1'b1);

        // all requesting with commits every cycle
        repeat (16) run_cycle('1, 1'b1, exp_q.size() > 0, 1'b0);
        run_cycle('0, 1'b0, 1'b0, 1'b1);

        // backpressure holds the slot
        obs_grants = 0;
        run_cycle('1, 1'b1, 1'b0, 1'b0);
        repeat (5) run_cycle('1, 1'b0, 1'b0, 1'b0);
        check_eq("bp_grants", 64'(obs_grants), 64'(1));
        run_cycle('1, 1'b1, 1'b0, 1'b0);
        run_cycle('0, 1'b0, 1'b0, 1'b1);

        // FIFO full: exactly N_PENDING grants, then commit-at-full defers the next grant
        obs_grants = 0;
        repeat (12) run_cycle('1, 1'b1, 1'b0, 1'b0);
        check_eq("full_grants", 64'(obs_grants), 64'(N_PENDING));
        run_cycle('1, 1'b1, 1'b1, 1'b0);
        check_eq("full_no_grant", 64'(obs_grants), 64'(N_PENDING));
        run_cycle('1, 1'b1, 1'b0, 1'b0);
        check_eq("full_next_grant", 64'(obs_grants), 64'(N_PENDING + 1));
        run_cycle('0, 1'b0, 1'b0, 1'b1);

        // spurious commit sets a sticky error
        run_cycle('0, 1'b1, 1'b1, 1'b0);
        repeat (3) run_cycle('0, 1'b1, 1'b0, 1'b0);
        run_cycle('0, 1'b0, 1'b0, 1'b1);
        run_cycle('0, 1'b0, 1'b0, 1'b0);

        // reset mid-run with pending tags and an occupied slot
        repeat (3) run_cycle('1, 1'b1, 1'b0, 1'b0);
        run_cycle('1, 1'b0, 1'b0, 1'b0);
        run_cycle('1, 1'b0, 1'b0, 1'b1);
        run_cycle('0, 1'b0, 1'b0, 1'b0);
        run_cycle('0, 1'b0, 1'b1, 1'b0);
        run_cycle('0, 1'b0, 1'b0, 1'b0);
        run_cycle('0, 1'b0, 1'b0, 1'b1);

        // random traffic
        repeat (600) begin
            r_rdy = N_SRC'($urandom());
            r_ack = ($urandom_range(0, 9) < 7);
            r_cmt = (exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
            r_rst = ($urandom_range(0, 99) == 0);
            run_cycle(r_rdy, r_ack, r_cmt, r_rst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
